// File: rtl/dl_pkg.sv
// dl_core shared definitions: opcodes, register indices, FSM states.
package dl_pkg;

  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_XOR = 5'b01011;
  localparam logic [4:0] OP_INC = 5'b01100;
  localparam logic [4:0] OP_NOT = 5'b01101;
  localparam logic [4:0] OP_ROR = 5'b01110;
  localparam logic [4:0] OP_ROL = 5'b01111;
  localparam logic [4:0] OP_SUB = 5'b11000;
  localparam logic [4:0] OP_DEC = 5'b11001;
  localparam logic [4:0] OP_HLT = 5'b11111;

  localparam logic [2:0] R_IN  = 3'd5;
  localparam logic [2:0] R_LED = 3'd6;
  localparam logic [2:0] R_PC  = 3'd7;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

endpackage

// File: rtl/dl_alu.sv
// dl_core combinational ALU: arithmetic, logic, rotate.
module dl_alu
  import dl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [4:0]   i_op,
  output logic [W-1:0] o_res,
  output logic         o_c,
  output logic         o_z
);

  logic [W:0] w_s;

  // MSB of the W+1 bit result is carry for adds, borrow for subtracts
  always_comb begin
    w_s = '0;
    case (i_op)
      OP_ADD:  w_s = {1'b0, i_a} + {1'b0, i_b};
      OP_OR:   w_s = {1'b0, i_a | i_b};
      OP_AND:  w_s = {1'b0, i_a & i_b};
      OP_XOR:  w_s = {1'b0, i_a ^ i_b};
      OP_INC:  w_s = {1'b0, i_b} + (W+1)'(1);
      OP_NOT:  w_s = {1'b0, ~i_b};
      OP_ROR:  w_s = {1'b0, i_b[0], i_b[W-1:1]};
      OP_ROL:  w_s = {1'b0, i_b[W-2:0], i_b[W-1]};
      OP_SUB:  w_s = {1'b0, i_a} - {1'b0, i_b};
      OP_DEC:  w_s = {1'b0, i_b} - (W+1)'(1);
      default: w_s = '0;
    endcase
  end

  assign o_res = w_s[W-1:0];
  assign o_c   = w_s[W];
  assign o_z   = ~|w_s[W-1:0];

endmodule

// File: rtl/dl_core.sv
// dl_core: tiny 8-register accumulator CPU, one instruction per cycle.
module dl_core
  import dl_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] btn,
  input  logic [7:0]        dout,
  input  logic              imem_valid,
  output logic [DATA_W-1:0] led,
  output logic [PC_W-1:0]   adr,
  output logic              halted
);

  logic [DATA_W-1:0] r_gpr [0:7];
  logic [DATA_W-1:0] r_sync1, r_sync2;
  logic [PC_W-1:0]   r_pc;
  logic              r_c, r_z;
  state_t            r_state;

  logic [4:0]        w_op;
  logic [2:0]        w_sss, w_ddd;
  logic [DATA_W-1:0] w_rs, w_imm, w_res;
  logic [PC_W-1:0]   w_pc1, w_tgt;
  logic              w_alu_c, w_alu_z;
  logic              w_setc, w_setz;

  assign w_op  = dout[7:3];
  assign w_sss = dout[2:0];
  assign w_ddd = w_op[2:0];
  assign w_imm = DATA_W'({w_op[0], w_sss});
  assign w_pc1 = r_pc + PC_W'(1);
  assign w_tgt = (r_pc & ~PC_W'(4'hF))
               | PC_W'({w_op[0], w_sss});

  // r5 is the synchroniser output, r7 is the PC
  always_comb begin
    if (w_sss == R_IN)
      w_rs = r_sync2;
    else if (w_sss == R_PC)
      w_rs = DATA_W'(r_pc);
    else
      w_rs = r_gpr[w_sss];
  end

  assign w_setc = (w_op == OP_ADD) || (w_op == OP_INC)
               || (w_op == OP_SUB) || (w_op == OP_DEC);
  assign w_setz = w_setc || (w_op == OP_OR)
               || (w_op == OP_AND) || (w_op == OP_XOR)
               || (w_op == OP_NOT);

  dl_alu #(.W(DATA_W)) u_alu (
    .i_a   (r_gpr[0]),
    .i_b   (w_rs),
    .i_op  (w_op),
    .o_res (w_res),
    .o_c   (w_alu_c),
    .o_z   (w_alu_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_gpr[i] <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_pc    <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_state <= S_RUN;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      if (r_state == S_RUN && imem_valid) begin
        if (w_setc) r_c <= w_alu_c;
        if (w_setz) r_z <= w_alu_z;
        casez (w_op)
          5'b00???: begin
            if (w_ddd == R_PC) begin
              r_pc <= PC_W'(w_rs);
            end else begin
              if (w_ddd != R_IN) r_gpr[w_ddd] <= w_rs;
              r_pc <= w_pc1;
            end
          end
          OP_ADD, OP_OR, OP_AND, OP_XOR, OP_SUB: begin
            r_gpr[0] <= w_res;
            r_pc     <= w_pc1;
          end
          OP_INC, OP_NOT, OP_ROR, OP_ROL, OP_DEC: begin
            if (w_sss == R_PC) begin
              r_pc <= PC_W'(w_res);
            end else begin
              if (w_sss != R_IN) r_gpr[w_sss] <= w_res;
              r_pc <= w_pc1;
            end
          end
          5'b1000?: begin
            r_pc <= r_c ? w_pc1 : w_tgt;
            r_c  <= 1'b0;
          end
          5'b1001?: r_pc <= w_tgt;
          5'b1010?: begin
            r_gpr[0] <= w_imm;
            r_pc     <= w_pc1;
          end
          5'b1011?: r_pc <= r_z ? w_tgt : w_pc1;
          OP_HLT:   r_state <= S_HALT;
          default:  r_pc <= w_pc1;
        endcase
      end
    end
  end

  assign led    = r_gpr[R_LED];
  assign adr    = r_pc;
  assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_dl_core.sv
// dl_core bench: instruction-level reference model and output scoreboard.
module tb_dl_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, v0, h0;
  logic [3:0] btn0, led0, adr0;
  logic [7:0] dout0;
  logic [7:0] rom0 [0:15];
  assign dout0 = rom0[adr0];

  logic       rst1, v1, h1;
  logic [7:0] btn1, led1, dout1;
  logic [5:0] adr1;
  logic [7:0] rom1 [0:63];
  assign dout1 = rom1[adr1];

  dl_core u0 (
    .clk(clk), .reset(rst0), .btn(btn0), .dout(dout0),
    .imem_valid(v0), .led(led0), .adr(adr0), .halted(h0)
  );

  dl_core #(.DATA_W(8), .PC_W(6)) u1 (
    .clk(clk), .reset(rst1), .btn(btn1), .dout(dout1),
    .imem_valid(v1), .led(led1), .adr(adr1), .halted(h1)
  );

  typedef struct packed {
    logic [7:0][31:0] r;
    logic             c;
    logic             z;
    logic             h;
    logic [31:0]      s1;
    logic [31:0]      s2;
  } ms_t;

  typedef struct {
    int led;
    int adr;
    int h;
  } ex_t;

  ms_t m0, m1;
  ex_t q0[$], q1[$];
  ex_t e0, e1;
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic logic [7:0] ins(int op, int s);
    return 8'((op << 3) | s);
  endfunction

  // Architectural interpreter: one call = one clock edge
  function automatic ms_t mstep(input ms_t m, input bit rst, input bit v,
                                input int bt, input int iw,
                                input int dw, input int pw);
    ms_t n;
    int dm, pm, op, s, rs, r0, imm, pc, npc, tgt, res, sum, dst;
    bit zf;
    n = '0;
    if (rst) return n;
    n = m;
    n.s1 = bt;
    n.s2 = m.s1;
    if (m.h || !v) return n;
    dm  = (1 << dw) - 1;
    pm  = (1 << pw) - 1;
    op  = (iw >> 3) & 31;
    s   = iw & 7;
    pc  = int'(m.r[7]);
    r0  = int'(m.r[0]);
    rs  = (s == 5) ? int'(m.s2) : (s == 7) ? (pc & dm) : int'(m.r[s]);
    imm = ((op & 1) << 3) | s;
    npc = (pc + 1) & pm;
    tgt = (pc & ~15) | imm;
    res = 0; dst = -1; zf = 0;
    n.r[7] = npc;
    case (op)
      0, 1, 2, 3, 4, 5, 6, 7: begin dst = op; res = rs; end
      8:  begin sum = r0 + rs; n.c = (sum > dm); res = sum & dm; zf = 1; dst = 0; end
      9:  begin res = r0 | rs; zf = 1; dst = 0; end
      10: begin res = r0 & rs; zf = 1; dst = 0; end
      11: begin res = r0 ^ rs; zf = 1; dst = 0; end
      12: begin sum = rs + 1; n.c = (sum > dm); res = sum & dm; zf = 1; dst = s; end
      13: begin res = ~rs & dm; zf = 1; dst = s; end
      14: begin res = (rs >> 1) | ((rs & 1) << (dw - 1)); dst = s; end
      15: begin res = ((rs << 1) & dm) | (rs >> (dw - 1)); dst = s; end
      24: begin n.c = (r0 < rs); res = (r0 - rs) & dm; zf = 1; dst = 0; end
      25: begin n.c = (rs == 0); res = (rs - 1) & dm; zf = 1; dst = s; end
      16, 17: begin n.r[7] = m.c ? npc : tgt; n.c = 0; end
      18, 19: n.r[7] = tgt;
      20, 21: begin res = imm; dst = 0; end
      22, 23: n.r[7] = m.z ? tgt : npc;
      31: begin n.h = 1; n.r[7] = pc; end
      default: ;
    endcase
    if (zf) n.z = (res == 0);
    if (dst == 7) n.r[7] = res & pm;
    else if (dst >= 0 && dst != 5) n.r[dst] = res;
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("d0.adr", int'(adr0), e0.adr);
      chk("d0.led", int'(led0), e0.led);
      chk("d0.halted", int'(h0), e0.h);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("d1.adr", int'(adr1), e1.adr);
      chk("d1.led", int'(led1), e1.led);
      chk("d1.halted", int'(h1), e1.h);
    end
  end

  task automatic cyc0(bit rst, bit v, int bt);
    int iw;
    @(negedge clk);
    rst0 = rst; v0 = v; btn0 = 4'(bt);
    iw = int'(rom0[int'(m0.r[7]) & 15]);
    m0 = mstep(m0, rst, v, bt & 15, iw, 4, 4);
    q0.push_back('{int'(m0.r[6]), int'(m0.r[7]), int'(m0.h)});
  endtask

  task automatic cyc1(bit rst, bit v, int bt);
    int iw;
    @(negedge clk);
    rst1 = rst; v1 = v; btn1 = 8'(bt);
    iw = int'(rom1[int'(m1.r[7]) & 63]);
    m1 = mstep(m1, rst, v, bt & 255, iw, 8, 6);
    q1.push_back('{int'(m1.r[6]), int'(m1.r[7]), int'(m1.h)});
  endtask

  // mode 0: stalled, 1: valid, 2: random valid with rare resets
  task automatic run0(int n, int mode, int bt);
    for (int i = 0; i < n; i++) begin
      cyc0(mode == 2 && $urandom_range(0, 63) == 0,
           mode == 2 ? 1'($urandom_range(0, 1)) : 1'(mode),
           bt < 0 ? int'($urandom_range(0, 15)) : bt);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run1(int n, int mode, int bt);
    for (int i = 0; i < n; i++) begin
      cyc1(mode == 2 && $urandom_range(0, 63) == 0,
           mode == 2 ? 1'($urandom_range(0, 1)) : 1'(mode),
           bt < 0 ? int'($urandom_range(0, 255)) : bt);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic nop0();
    for (int i = 0; i < 16; i++) rom0[i] = ins(26, 0);
  endtask

  initial begin
    rst0 = 1'b1; v0 = 1'b0; btn0 = '0;
    rst1 = 1'b1; v1 = 1'b0; btn1 = '0;
    m0 = '0; m1 = '0;
    nop0();
    for (int i = 0; i < 64; i++) rom1[i] = ins(26, 0);

    // INC overflow sets C; JNC falls through and clears C
    rom0[0] = ins(21, 1);
    for (int i = 1; i < 8; i++) rom0[i] = ins(12, 0);
    rom0[8]  = ins(16, 3);
    rom0[9]  = ins(6, 0);
    rom0[10] = ins(16, 14);
    rom0[14] = ins(31, 0);
    cyc0(1, 0, 0);
    run0(9, 1, 0);
    chk("jnc_fallthru_adr", int'(adr0), 9);
    run0(2, 1, 0);
    chk("jnc_taken_adr", int'(adr0), 14);
    chk("inc_wrap_led", int'(led0), 0);
    run0(1, 1, 0);
    chk("hlt_a", int'(h0), 1);

    // SUB to zero then JZ, with a stall in the middle
    nop0();
    rom0[0] = ins(20, 5);
    rom0[1] = ins(6, 0);
    rom0[2] = ins(1, 0);
    rom0[3] = ins(24, 1);
    rom0[4] = ins(23, 4);
    rom0[12] = ins(6, 0);
    cyc0(1, 0, 0);
    run0(2, 1, 0);
    chk("pre_stall_led", int'(led0), 5);
    run0(3, 0, 0);
    chk("stall_adr", int'(adr0), 2);
    chk("stall_led", int'(led0), 5);
    run0(3, 1, 0);
    chk("jz_adr", int'(adr0), 12);
    run0(1, 1, 0);
    chk("sub_zero_led", int'(led0), 0);

    // btn through synchroniser; writes to r5 discarded
    nop0();
    rom0[2] = ins(6, 5);
    rom0[3] = ins(20, 3);
    rom0[4] = ins(5, 0);
    rom0[5] = ins(12, 5);
    rom0[6] = ins(6, 5);
    rom0[7] = ins(31, 0);
    cyc0(1, 0, 10);
    run0(3, 1, 10);
    chk("btn_led", int'(led0), 10);
    run0(4, 1, 10);
    chk("r5_readonly_led", int'(led0), 10);

    // HALT holds regardless of imem_valid; reset releases
    nop0();
    rom0[0] = ins(21, 1);
    rom0[1] = ins(6, 0);
    rom0[6] = ins(31, 0);
    cyc0(1, 0, 0);
    run0(7, 1, 0);
    chk("halt_flag", int'(h0), 1);
    chk("halt_adr", int'(adr0), 6);
    run0(10, 2, -1);
    chk("halt_hold_adr", int'(adr0), 6);
    chk("halt_hold_led", int'(led0), 9);
    cyc0(1, 0, 0);
    @(posedge clk);
    #2;
    chk("reset_halted", int'(h0), 0);
    chk("reset_adr", int'(adr0), 0);
    chk("reset_led", int'(led0), 0);

    for (int ep = 0; ep < 10; ep++) begin
      for (int i = 0; i < 16; i++)
        rom0[i] = ($urandom_range(0, 3) == 0) ?
                  ins(6, int'($urandom_range(0, 7))) : 8'($urandom);
      cyc0(1, 0, 0);
      run0(300, 2, -1);
    end
    v0 = 1'b0;

    // wide configuration: page jump, 8-bit rotate, PC wrap
    rom1[23] = ins(18, 3);
    cyc1(1, 0, 0);
    run1(23, 1, 0);
    chk("w_adr_17", int'(adr1), 'h17);
    run1(1, 1, 0);
    chk("w_jmp_page", int'(adr1), 'h13);
    rom1['h13] = ins(20, 3);
    rom1['h14] = ins(14, 0);
    rom1['h15] = ins(6, 0);
    rom1['h16] = ins(15, 0);
    rom1['h17] = ins(6, 0);
    run1(3, 1, 0);
    chk("w_ror_led", int'(led1), 'h81);
    run1(2, 1, 0);
    chk("w_rol_led", int'(led1), 'h03);
    run1(39, 1, 0);
    chk("w_adr_3f", int'(adr1), 'h3F);
    run1(1, 1, 0);
    chk("w_pc_wrap", int'(adr1), 0);

    for (int ep = 0; ep < 4; ep++) begin
      for (int i = 0; i < 64; i++)
        rom1[i] = ($urandom_range(0, 3) == 0) ?
                  ins(6, int'($urandom_range(0, 7))) : 8'($urandom);
      cyc1(1, 0, 0);
      run1(300, 2, -1);
    end

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dl_core.md
DL_CORE -- requirements
Module: dl_core

Interface
REQ-001 Parameter DATA_W, default 4, register/ALU data width (>=4).
REQ-002 Parameter PC_W, default 4, program-counter/instruction-address width (>=4).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn  input  DATA_W  asynchronous input port, read as r5.
REQ-006 dout  input  8  instruction word at address adr; op=dout[7:3], sss=dout[2:0].
REQ-007 imem_valid  input  1  dout valid this cycle; low = stall.
REQ-008 led  output  DATA_W  continuous copy of r6.
REQ-009 adr  output  PC_W  continuous copy of r7 (PC).
REQ-010 halted  output  1  high while in HALT state.

Function
REQ-011 Eight registers r0..r7 of DATA_W bits (r7 is PC_W bits); flags C, Z; FSM states RUN, HALT.
REQ-012 btn passes through a 2-flop synchroniser; r5 reads the second flop; writes to r5 are discarded.
REQ-013 In RUN with imem_valid=1, exactly one instruction executes per cycle; with imem_valid=0, no register, flag, PC or state change.
REQ-014 imm = {op[0],sss} zero-extended to DATA_W; jump target = {PC[PC_W-1:4], imm} (page-relative).
REQ-015 00ddd MOV: r[ddd] <= r[sss]; ddd=7 loads PC with r[sss] truncated/zero-extended, no increment.
REQ-016 01000 ADD: r0 <= r0+rs mod 2^DATA_W; C <= carry-out; Z <= (result==0).
REQ-017 01001 OR, 01010 AND, 01011 XOR: r0 <= r0 op rs; Z updated; C unchanged.
REQ-018 01100 INC: rs <= rs+1; C <= carry-out; Z updated.
REQ-019 01101 NOT: rs <= bitwise inverse of rs; Z updated.
REQ-020 01110 ROR / 01111 ROL: one-bit rotate of rs over DATA_W bits; flags unchanged.
REQ-021 11000 SUB: r0 <= r0-rs; C <= borrow (r0<rs); Z updated. 11001 DEC: rs <= rs-1; C <= borrow; Z updated.
REQ-022 1000x JNC: PC <= target if C==0, else PC+1; C cleared in both cases.
REQ-023 1001x JMP: PC <= target unconditionally.
REQ-024 1010x MVI: r0 <= imm; flags unchanged.
REQ-025 1011x JZ: PC <= target if Z==1, else PC+1; Z unchanged.
REQ-026 11111 HLT: state <= HALT; PC unchanged; halted=1 from next cycle.
REQ-027 All other op codes: NOP (PC+1 only).
REQ-028 Every non-jump instruction whose destination is not r7 increments PC by 1, wrapping 2^PC_W-1 -> 0.
REQ-029 ALU ops whose destination rs is r7 write PC with the result; no further increment.
REQ-030 ALU/INC/DEC/NOT/rotate with rs=r5 compute flags but discard the register write.
REQ-031 HALT is left only by reset; imem_valid ignored in HALT.

Reset
REQ-032 reset=1 at a clock edge forces r0..r7=0, C=0, Z=0, sync flops=0, state=RUN; led=0, adr=0, halted=0 next cycle.
REQ-033 Reset has priority over stall, HALT and any instruction in flight.

Structure
REQ-034 Package dl_pkg holds the 5-bit opcode constants, FSM state enum and register-index constants (R_IN=5, R_LED=6, R_PC=7).
REQ-035 One combinational sub-module dl_alu (operands, op -> result, carry, zero) is instantiated once in dl_core.

Verification
REQ-036 Reset then MVI 9; INC r0 x7 (DATA_W=4) -> r0=0, C=1 after 7th INC; next JNC 3 falls through to PC+1 and C=0.
REQ-037 MVI 5; MOV r1,r0; SUB r1 -> r0=0, Z=1; JZ 12 -> adr=12.
REQ-038 imem_valid=0 for 3 cycles mid-program -> adr, led, r0..r6, C, Z unchanged; resumes on same instruction.
REQ-039 btn=4'hA; MOV r6,r5 two cycles later -> led=4'hA; writes to r5 leave it tracking btn.
REQ-040 HLT at PC=6 -> halted=1, adr=6 held 10 cycles; reset -> halted=0, adr=0.
REQ-041 DATA_W=8, PC_W=6, PC=0x17: JMP 3 -> adr=0x13; ROL on 0x81 -> 0x03; PC 0x3F+1 -> 0x00.
